uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 10_000_000, serial bit rate in bits/s.
REQ-003 Parameter FIFO_DEPTH, default 8, byte capacity of the transmit buffer; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 data_in_valid  input  1  producer asserts when data_in holds a byte.
REQ-008 data_in_ready  output  1  block can accept a byte this cycle.
REQ-009 serial_out  output  1  UART line, idle high.
REQ-010 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered; excludes the byte being shifted.

Function
REQ-012 Byte accepted on a rising edge where data_in_valid && data_in_ready; it is written to the FIFO tail at that edge.
REQ-013 data_in_ready SHALL equal !full, combinational from registered FIFO state; an accept and a pop in the same cycle while full SHALL NOT occur (ready already low).
REQ-014 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bits total; no parity.
REQ-015 SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division); each bit SHALL be driven for exactly SYMBOL_EDGE_TIME cycles.
REQ-016 Transmit FSM states: IDLE, START, DATA, STOP.
- IDLE: serial_out=1; if FIFO non-empty, pop the head and enter START at the same edge.
- START: hold 0, then go to DATA.
- DATA: 3-bit bit index 0..7; after bit 7, go to STOP.
- STOP: hold 1; at end, pop and go to START if FIFO non-empty, else go to IDLE.
REQ-017 Latency: byte accepted into an empty FIFO with FSM in IDLE at edge N SHALL pop at edge N+1; serial_out is low from edge N+1.
REQ-018 Back-to-back: consecutive buffered bytes SHALL be sent with zero idle cycles between the stop bit and the next start bit; a frame is exactly 10*SYMBOL_EDGE_TIME cycles.
REQ-019 Simultaneous push and pop in one cycle SHALL be legal when the FIFO is neither full nor empty; fifo_count is unchanged.
REQ-020 Byte order on the line SHALL equal acceptance order.
REQ-021 A push while full SHALL be ignored; fifo_count and contents are unchanged.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL use a count or an extra pointer bit, never an ambiguous pointer compare.
REQ-023 serial_out SHALL be registered (glitch-free).

Reset
REQ-024 On rst: FSM=IDLE, serial_out=1, FIFO emptied (fifo_count=0), bit and cycle counters=0, busy=0, data_in_ready=1, all from the next edge.
REQ-025 rst asserted mid-frame SHALL abort the frame; the line returns high at the next edge and buffered bytes are discarded.
REQ-026 Inputs SHALL be ignored while rst is high.

Structure
REQ-027 Shared package: FSM state encoding, UART frame constants (start=0, stop=1, data width 8, frame bits 10).
REQ-028 One sub-module, sync_fifo (parameterized width/depth, push/pop/full/empty/count); the FSM and bit timer live in uart_tx_buffered.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000, SYMBOL_EDGE_TIME=5)
REQ-029 Reset for 10 cycles -> serial_out=1, data_in_ready=1, busy=0, fifo_count=0.
REQ-030 Push 8'h61 once -> serial_out: 0 for 5 cycles, then 1,0,0,0,0,1,1,0, each for 5 cycles, then 1; frame is 50 cycles; a mid-bit-sampling receiver reads 8'h61.
REQ-031 Push 8'h0d, 8'h0a, 8'h31, 8'h35 on consecutive cycles -> same four bytes received in order; line continuously framed for 200 cycles, with no idle gap.
REQ-032 Hold valid for FIFO_DEPTH+3 consecutive cycles -> exactly FIFO_DEPTH+1 accepted (one popped at the first pop edge); ready low while fifo_count=8; ready high again one cycle after the next pop; rejected bytes never appear on the line.
REQ-033 Push 8'h00 then 8'hff -> data bits all 0, then all 1; start and stop bits correct.
REQ-034 Push 8'hca, then assert rst for 1 cycle during data bit 3 -> serial_out=1 from the next edge, fifo_count=0, busy=0; then push 8'hfe -> a complete correct frame.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states and
// frame constants.
package uart_tx_buffered_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_e;

   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS = 10;

   function automatic int unsigned symbol_cycles(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are dropped.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by plain overflow.
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter (8N1) fed from a byte FIFO; back-to-back frames are sent
// with no idle gap.
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 10_000_000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  data_in,
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   output logic                        serial_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned SYM = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned CW  = (SYM > 1) ? $clog2(SYM) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(SYM - 1);
   localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

   tx_state_e            state_q;
   logic [CW-1:0]        cyc_q;
   logic [2:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 serial_q;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_head;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (data_in),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign fifo_push     = data_in_valid && !rst;
   assign data_in_ready = !fifo_full;
   assign serial_out    = serial_q;
   assign busy          = (state_q != ST_IDLE) || !fifo_empty;

   // Pop either from idle or on the last stop-bit cycle, so the next start
   // bit follows the stop bit without a gap.
   always_comb begin
      fifo_pop = 1'b0;
      if (!rst && !fifo_empty) begin
         fifo_pop = (state_q == ST_IDLE) ||
                    ((state_q == ST_STOP) && (cyc_q == CYC_LAST));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cyc_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= STOP_BIT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               serial_q <= STOP_BIT;
               if (fifo_pop) begin
                  state_q  <= ST_START;
                  cyc_q    <= '0;
                  shift_q  <= fifo_head;
                  serial_q <= START_BIT;
               end
            end
            ST_START: begin
               if (cyc_q == CYC_LAST) begin
                  state_q  <= ST_DATA;
                  cyc_q    <= '0;
                  bit_q    <= '0;
                  serial_q <= shift_q[0];
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            ST_DATA: begin
               if (cyc_q == CYC_LAST) begin
                  cyc_q <= '0;
                  if (bit_q == BIT_LAST) begin
                     state_q  <= ST_STOP;
                     serial_q <= STOP_BIT;
                  end else begin
                     bit_q    <= bit_q + 3'd1;
                     serial_q <= shift_q[bit_q + 3'd1];
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            ST_STOP: begin
               if (cyc_q == CYC_LAST) begin
                  cyc_q <= '0;
                  if (fifo_pop) begin
                     state_q  <= ST_START;
                     shift_q  <= fifo_head;
                     serial_q <= START_BIT;
                  end else begin
                     state_q  <= ST_IDLE;
                     serial_q <= STOP_BIT;
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               serial_q <= STOP_BIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed vector table, corner-case sequences and
// random traffic against a frame-level reference model and a mid-bit receiver.
module tb_uart_tx_buffered;

   localparam int unsigned CLK_F = 50_000_000;
   localparam int unsigned BAUD  = 10_000_000;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned SYM   = CLK_F / BAUD;
   localparam int unsigned FRAME = 10 * SYM;
   localparam int          NV    = 9;

   logic       clk = 1'b0;
   logic       rst, data_in_valid, data_in_ready, serial_out, busy;
   logic [7:0] data_in;
   logic [3:0] fifo_count;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLOCK_FREQ (CLK_F),
      .BAUD_RATE  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out),
      .busy          (busy),
      .fifo_count    (fifo_count)
   );

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [7:0] data;
      logic       ready;
      logic       busy;
      logic [3:0] count;
      logic       serial;
   } vec_t;

   vec_t vecs [NV];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: buffered bytes plus the remaining length of the frame on the line.
   logic [7:0] mq[$];
   logic [7:0] exp_rx[$];
   int         frame_left = 0;
   logic [7:0] cur_byte = '0;
   logic       hs;

   // Receiver
   logic [7:0] rx_hist[$];
   int         start_q[$];
   logic       rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = '0;
   logic       line_log [0:16383];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_line();
      int k, b;
      if (frame_left == 0) return 1'b1;
      k = FRAME - frame_left;
      b = k / SYM;
      if (b == 0) return 1'b0;
      if (b <= 8) return cur_byte[b-1];
      return 1'b1;
   endfunction

   task automatic model_step(input logic r, input logic v, input logic [7:0] d);
      logic rdy, ending;
      if (r) begin
         if (frame_left > 0 && exp_rx.size() > 0) void'(exp_rx.pop_back());
         mq.delete();
         frame_left = 0;
      end else begin
         rdy    = (mq.size() < DEPTH);
         ending = (frame_left <= 1);
         if (frame_left > 0) frame_left--;
         if (ending && mq.size() > 0) begin
            cur_byte = mq.pop_front();
            exp_rx.push_back(cur_byte);
            frame_left = FRAME;
         end
         if (v && rdy) mq.push_back(d);
      end
   endtask

   task automatic check_outputs();
      logic [6:0] act, exp;
      act = {data_in_ready, busy, fifo_count, serial_out};
      exp = {mq.size() < DEPTH, (frame_left > 0) || (mq.size() > 0), 4'(mq.size()), exp_line()};
      check($sformatf("cycle%0d {ready,busy,count,line}", cyc), 64'(act), 64'(exp));
   endtask

   task automatic rx_step(input logic r);
      int b;
      if (r) begin
         rx_active = 1'b0;
      end else begin
         if (!rx_active) begin
            if (serial_out == 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
               start_q.push_back(cyc);
            end
         end else begin
            rx_cnt++;
         end
         if (rx_active && (rx_cnt % SYM) == (SYM / 2)) begin
            b = rx_cnt / SYM;
            if (b == 0) begin
               check("rx start bit", 64'(serial_out), 64'd0);
            end else if (b <= 8) begin
               rx_byte[b-1] = serial_out;
            end else begin
               check("rx stop bit", 64'(serial_out), 64'd1);
               rx_hist.push_back(rx_byte);
               if (exp_rx.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rx unexpected byte: got %0h expected none", rx_byte);
               end else begin
                  check("rx byte order", 64'(rx_byte), 64'(exp_rx.pop_front()));
               end
               rx_active = 1'b0;
            end
         end
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic [7:0] d);
      rst           = r;
      data_in_valid = v;
      data_in       = d;
      hs = v && !r && (data_in_ready === 1'b1);
      @(posedge clk);
      model_step(r, v, d);
      @(negedge clk);
      check_outputs();
      line_log[cyc % 16384] = serial_out;
      rx_step(r);
      cyc++;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((frame_left > 0 || mq.size() > 0 || rx_active) && n < budget) begin
         cycle(1'b0, 1'b0, 8'($urandom));
         n++;
      end
      if (frame_left > 0 || mq.size() > 0 || rx_active) begin
         checks++;
         failures++;
         $display("FAIL drain timeout: got busy after %0d cycles expected idle", budget);
      end
      cycle(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int push_cyc, n0, acc;
      logic [9:0]  bits61;
      logic [49:0] got, want;
      logic [7:0]  b4 [4];

      rst = 1'b1;
      data_in_valid = 1'b0;
      data_in = '0;

      vecs[0] = '{1'b1, 1'b1, 8'h5a, 1'b1, 1'b0, 4'd0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 8'h61, 1'b1, 1'b1, 4'd1, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b1};

      repeat (10) cycle(1'b1, 1'b0, 8'h00);
      check("reset {line,ready,busy,count}",
            64'({serial_out, data_in_ready, busy, fifo_count}), 64'(7'b1_1_0_0000));

      push_cyc = 0;
      for (int i = 0; i < NV; i++) begin
         cycle(vecs[i].rst, vecs[i].valid, vecs[i].data);
         check($sformatf("vec%0d {ready,busy,count,line}", i),
               64'({data_in_ready, busy, fifo_count, serial_out}),
               64'({vecs[i].ready, vecs[i].busy, vecs[i].count, vecs[i].serial}));
         if (i == 1) push_cyc = cyc - 1;
      end
      wait_idle(200);

      bits61 = 10'b1011000010;
      for (int k = 0; k < 50; k++) begin
         got[k]  = line_log[(push_cyc + 1 + k) % 16384];
         want[k] = bits61[k / SYM];
      end
      check("0x61 waveform", 64'(got), 64'(want));
      check("0x61 line idle after frame", 64'(line_log[(push_cyc + 51) % 16384]), 64'd1);
      check("0x61 received", 64'(rx_hist[$]), 64'h61);

      b4[0] = 8'h0d; b4[1] = 8'h0a; b4[2] = 8'h31; b4[3] = 8'h35;
      n0 = start_q.size();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, b4[i]);
      wait_idle(4 * FRAME + 50);
      check("4-byte frame count", 64'(start_q.size() - n0), 64'd4);
      if (start_q.size() - n0 == 4) begin
         for (int i = 1; i < 4; i++)
            check($sformatf("4-byte start gap %0d", i),
                  64'(start_q[n0+i] - start_q[n0+i-1]), 64'(FRAME));
         for (int i = 0; i < 4; i++)
            check($sformatf("4-byte rx %0d", i), 64'(rx_hist[rx_hist.size()-4+i]), 64'(b4[i]));
      end

      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'hff);
      wait_idle(2 * FRAME + 50);
      check("rx 0x00", 64'(rx_hist[rx_hist.size()-2]), 64'h00);
      check("rx 0xff", 64'(rx_hist[$]), 64'hff);

      acc = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         cycle(1'b0, 1'b1, 8'(8'h80 + i));
         if (hs) acc++;
      end
      check("burst accepted", 64'(acc), 64'(DEPTH + 1));
      wait_idle((DEPTH + 1) * FRAME + 50);
      check("burst last rx byte", 64'(rx_hist[$]), 64'h88);

      n0 = rx_hist.size();
      cycle(1'b0, 1'b1, 8'hca);
      repeat (22) cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 8'h77);
      check("abort {line,busy,count}", 64'({serial_out, busy, fifo_count}), 64'(6'b1_0_0000));
      cycle(1'b0, 1'b1, 8'hfe);
      wait_idle(FRAME + 50);
      check("abort rx count", 64'(rx_hist.size() - n0), 64'd1);
      check("after abort rx 0xfe", 64'(rx_hist[$]), 64'hfe);

      for (int i = 0; i < 1000; i++) begin
         if (i < 500) cycle(1'b0, $urandom_range(0, 3) == 0, 8'($urandom));
         else         cycle(1'b0, $urandom_range(0, 40) == 0, 8'($urandom));
      end
      wait_idle((DEPTH + 1) * FRAME + 100);
      check("random all bytes delivered", 64'(exp_rx.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
